// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product controller: command encoding,
// FSM state type and default datapath dimensions.
package dotprod_pkg;

  localparam int MEM_DEPTH_DEF    = 35;
  localparam int RESULT_W_DEF     = 20;
  localparam int RESULT_BYTES_DEF = (RESULT_W_DEF + 7) / 8;
  localparam int RUN_STAGES       = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_RUN   = 2'd1,
    OP_READ  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_READ
  } state_e;

endpackage

// File: rtl/dotprod_ctrl.sv
// Command sequencer for the dot-product datapath: loads/clears operand memory,
// steps the adder-tree pipeline and streams the captured result out bytewise.
module dotprod_ctrl
  import dotprod_pkg::*;
#(
  parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int RESULT_W     = RESULT_W_DEF,
  parameter int RESULT_BYTES = RESULT_BYTES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  output logic                cmd_ready,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [5:0]          mem_addr,
  output logic [7:0]          mem_wdata,
  output logic [3:0]          stage_en,
  input  logic [RESULT_W-1:0] result_in,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [5:0] LAST_ADDR   = 6'(MEM_DEPTH - 1);
  localparam logic [5:0] LAST_BYTE   = 6'(RESULT_BYTES - 1);
  localparam logic [5:0] CAPTURE_CNT = 6'(RUN_STAGES);
  localparam int         PADDED_W    = 8 * RESULT_BYTES;

  state_e              r_state;
  logic [5:0]          r_cnt;
  logic [RESULT_W-1:0] r_resultReg;

  logic                w_act;
  logic [PADDED_W-1:0] w_padded;
  logic [7:0]          w_byte;

  assign w_act    = ena & rst_n;
  assign w_padded = PADDED_W'(r_resultReg);

  // r_cnt doubles as memory address, pipeline stage index and output byte index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_resultReg <= '0;
    end else if (ena) begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cnt <= '0;
            case (cmd_op_e'(cmd_op))
              OP_LOAD:  r_state <= ST_LOAD;
              OP_RUN:   r_state <= ST_RUN;
              OP_READ:  r_state <= ST_READ;
              OP_CLEAR: r_state <= ST_CLEAR;
              default:  r_state <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (r_cnt == LAST_ADDR) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_RUN: begin
          if (r_cnt == CAPTURE_CNT) begin
            r_resultReg <= result_in;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_READ: begin
          if (out_ready) begin
            if (r_cnt == LAST_BYTE) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = '0;
    for (int b = 0; b < RESULT_BYTES; b++) begin
      if (r_cnt == 6'(b)) w_byte = w_padded[8*b +: 8];
    end
  end

  // Handshake and strobe outputs are decoded combinationally so a load byte is
  // written in the cycle it is accepted; everything is forced low when frozen.
  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stage_en  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = rst_n & (r_state != ST_IDLE);
    if (w_act) begin
      case (r_state)
        ST_IDLE: cmd_ready = 1'b1;
        ST_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mem_we    = 1'b1;
            mem_addr  = r_cnt;
            mem_wdata = in_data;
          end
        end
        ST_CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = r_cnt;
        end
        ST_RUN: begin
          if (r_cnt < CAPTURE_CNT) stage_en = 4'b0001 << r_cnt[1:0];
        end
        ST_READ: begin
          out_valid = 1'b1;
          out_data  = w_byte;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dotprod_ctrl.sv
// Self-checking bench for dotprod_ctrl: directed scenarios plus randomized
// load/run/read traffic compared against a simple arithmetic result model.
module tb_dotprod_ctrl;
  import dotprod_pkg::*;

  localparam int DEPTH  = 35;
  localparam int NBYTES = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [3:0]  stage_en;
  logic [19:0] result_in;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] modelResult;
  logic [7:0]  loadData [DEPTH];

  dotprod_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stage_en(stage_en), .result_in(result_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendCmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    checkOutput("busy_idle", busy, 0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic applyLoad(input int gapAt, input int gapLen);
    sendCmd(OP_LOAD);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == gapAt) begin
        for (int g = 0; g < gapLen; g++) begin
          in_valid  = 1'b0;
          cmd_valid = 1'b1;
          cmd_op    = OP_RUN;
          #1;
          checkOutput("load_gap_we", mem_we, 0);
          checkOutput("load_gap_cmd_ready", cmd_ready, 0);
          checkOutput("load_gap_busy", busy, 1);
          tick();
        end
      end
      cmd_valid = 1'b0;
      in_valid  = 1'b1;
      in_data   = loadData[i];
      #1;
      checkOutput("load_we", mem_we, 1);
      checkOutput("load_addr", mem_addr, i);
      checkOutput("load_data", mem_wdata, loadData[i]);
      checkOutput("load_in_ready", in_ready, 1);
      checkOutput("load_busy", busy, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checkOutput("load_done_busy", busy, 0);
    checkOutput("load_done_we", mem_we, 0);
  endtask

  // result_in carries a decoy value except in the one cycle where capture must occur
  task automatic applyRun(input logic [19:0] res);
    sendCmd(OP_RUN);
    for (int k = 0; k < 4; k++) begin
      result_in = ~res;
      #1;
      checkOutput("run_stage", stage_en, 1 << k);
      checkOutput("run_busy", busy, 1);
      tick();
    end
    result_in = res;
    #1;
    checkOutput("run_stage_last", stage_en, 0);
    checkOutput("run_busy_last", busy, 1);
    tick();
    result_in   = 20'($urandom);
    modelResult = res;
    checkOutput("run_done_busy", busy, 0);
  endtask

  task automatic applyRead(input logic [15:0] pattern, input bit useRandom);
    int   got = 0;
    int   cyc = 0;
    logic rdy;
    sendCmd(OP_READ);
    while (got < NBYTES && cyc < 64) begin
      if (useRandom) rdy = 1'($urandom_range(0, 1));
      else           rdy = (cyc < 16) ? pattern[cyc] : 1'b1;
      out_ready = rdy;
      #1;
      checkOutput("read_valid", out_valid, 1);
      checkOutput("read_data", out_data, (32'(modelResult) >> (8 * got)) & 32'hFF);
      tick();
      if (rdy) got++;
      cyc++;
    end
    checkOutput("read_count", got, NBYTES);
    out_ready = 1'b0;
    #1;
    checkOutput("read_done_busy", busy, 0);
    checkOutput("read_done_valid", out_valid, 0);
  endtask

  task automatic applyClear(input int freezeAt, input int freezeLen);
    int writes = 0;
    int cyc    = 0;
    sendCmd(OP_CLEAR);
    while (writes < DEPTH && cyc < 100) begin
      ena = !(cyc >= freezeAt && cyc < freezeAt + freezeLen);
      #1;
      if (!ena) begin
        checkOutput("clear_freeze_we", mem_we, 0);
        checkOutput("clear_freeze_busy", busy, 1);
      end else begin
        checkOutput("clear_we", mem_we, 1);
        checkOutput("clear_addr", mem_addr, writes);
        checkOutput("clear_data", mem_wdata, 0);
        writes++;
      end
      tick();
      cyc++;
    end
    ena = 1'b1;
    #1;
    checkOutput("clear_cycles", cyc, DEPTH + freezeLen);
    checkOutput("clear_done_busy", busy, 0);
    checkOutput("clear_done_we", mem_we, 0);
  endtask

  task automatic applyStimulus();
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    in_valid = 1'b0; in_data = '0; result_in = '0; out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_stage_en", stage_en, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_cmd_ready", cmd_ready, 1);
    modelResult = '0;

    // no RUN yet: result reads back as zero
    applyRead(16'hFFFF, 1'b0);

    for (int i = 0; i < DEPTH; i++) loadData[i] = 8'(i + 1);
    applyLoad(-1, 0);

    applyRun(20'h38400);
    applyRead(16'hFFFF, 1'b0);
    applyRead(16'h0019, 1'b0);

    for (int i = 0; i < DEPTH; i++) loadData[i] = 8'($urandom);
    applyLoad(5, 10);
    applyRead(16'hFFFF, 1'b0);

    applyClear(10, 4);
    applyRead(16'hFFFF, 1'b0);

    // ena low in IDLE blocks command acceptance
    ena = 1'b0; cmd_valid = 1'b1; cmd_op = OP_RUN;
    #1;
    checkOutput("frozen_cmd_ready", cmd_ready, 0);
    tick();
    tick();
    ena = 1'b1; cmd_valid = 1'b0;
    #1;
    checkOutput("frozen_not_accepted", busy, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) loadData[i] = 8'($urandom);
      applyLoad(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)));
      applyRun(20'($urandom));
      applyRead(16'h0, 1'b1);
    end

    // reset asserted in the third RUN cycle
    sendCmd(OP_RUN);
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("rstrun_stage", stage_en, 1 << k);
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rstrun_cmd_ready", cmd_ready, 0);
    checkOutput("rstrun_busy", busy, 0);
    checkOutput("rstrun_stage_low", stage_en, 0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rstrun_after_stage", stage_en, 0);
    checkOutput("rstrun_after_busy", busy, 0);
    checkOutput("rstrun_after_cmd_ready", cmd_ready, 1);
    tick();
    #1;
    checkOutput("rstrun_idle_stage", stage_en, 0);
    modelResult = '0;
    applyRead(16'h0, 1'b1);
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dotprod_ctrl.md
DOTPROD_CTRL -- requirements
Module: dotprod_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 35, number of operand/config bytes in the datapath memory.
REQ-002 Parameter RESULT_W, default 20, width of the adder-tree result.
REQ-003 Parameter RESULT_BYTES, default 3, equal to ceil(RESULT_W/8).
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  design enable; low freezes all state.
- cmd_valid  in  1  command offered.
- cmd_op  in  2  0=LOAD, 1=RUN, 2=READ, 3=CLEAR.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- in_valid  in  1  load byte offered.
- in_data  in  8  load byte.
- in_ready  out  1  load byte accepted when in_valid & in_ready.
- mem_we  out  1  datapath memory write strobe.
- mem_addr  out  6  datapath memory address.
- mem_wdata  out  8  datapath memory write data.
- stage_en  out  4  one-hot enable: bit0 products, bit1 sum1, bit2 sum2, bit3 sum3.
- result_in  in  RESULT_W  final adder-tree output from the datapath.
- out_valid  out  1  result byte presented.
- out_data  out  8  result byte.
- out_ready  in  1  result byte consumed when out_valid & out_ready.
- busy  out  1  high in any state except IDLE.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, CLEAR, RUN, READ; cmd_ready = (state==IDLE) & ena.
REQ-006 An accepted command SHALL move IDLE to the state selected by cmd_op on the next edge and zero the byte counter cnt; commands offered while busy SHALL be ignored.
REQ-007 LOAD: in_ready = ena; each accepted byte SHALL drive mem_we=1, mem_addr=cnt, mem_wdata=in_data combinationally in the same cycle, then increment cnt.
REQ-008 LOAD SHALL return to IDLE on the edge accepting byte MEM_DEPTH-1; in_valid low stalls without timeout.
REQ-009 CLEAR SHALL write 0x00 to addresses 0..MEM_DEPTH-1, one per cycle, then return to IDLE (MEM_DEPTH cycles).
REQ-010 RUN: stage_en SHALL be 0001, 0010, 0100, 1000 on the four cycles after acceptance; on the fifth cycle result_in SHALL be captured into result_reg and the FSM SHALL return to IDLE.
REQ-011 Command-accept edge to result_reg update SHALL be exactly 5 enabled cycles.
REQ-012 READ: out_valid=1 and out_data = result_reg[8*cnt+7:8*cnt], upper bits of the last byte zero-filled, LSB byte first.
REQ-013 READ SHALL advance cnt only on out_valid & out_ready and return to IDLE after byte RESULT_BYTES-1 is consumed; out_ready low holds out_data stable.
REQ-014 ena low SHALL hold state, cnt and result_reg; mem_we, stage_en, in_ready, out_valid, cmd_ready SHALL be 0.
REQ-015 result_reg SHALL persist across LOAD/CLEAR; a READ before any RUN returns zeros.
REQ-016 Outside LOAD/CLEAR mem_we=0, mem_addr=0, mem_wdata=0; outside RUN stage_en=0.

Reset
REQ-017 rst_n low at a clock edge SHALL force IDLE, cnt=0, result_reg=0 from any state, including mid-LOAD/RUN/READ.
REQ-018 During and after reset: cmd_ready=0 while rst_n low, busy=0, mem_we=0, stage_en=0, in_ready=0, out_valid=0, out_data=0.

Structure
REQ-019 Package dotprod_pkg SHALL hold the cmd_op encoding, FSM state type, MEM_DEPTH, RESULT_W and RESULT_BYTES defaults.
REQ-020 Implementation SHALL be a single module; no sub-module.

Verification
REQ-021 LOAD, then 35 bytes 0x01..0x23 with in_valid held -> mem_we for 35 cycles, addr 0..34, data 0x01..0x23; busy drops after byte 0x23.
REQ-022 RUN with result_in=0x3_8400 -> stage_en 1,2,4,8 on successive cycles; READ returns 0x00, 0x84, 0x03.
REQ-023 READ with out_ready toggling 1,0,0,1,1 -> out_data holds during stalls; exactly 3 bytes transferred.
REQ-024 LOAD with in_valid low for 10 cycles after byte 5 -> no writes, cnt holds at 5; resumes at addr 5.
REQ-025 rst_n low during RUN cycle 3 -> next cycle IDLE, stage_en=0; subsequent READ returns 0x00 x3.
REQ-026 ena low for 4 cycles mid-CLEAR -> no writes during freeze; CLEAR completes 35 writes total.
